// File: rtl/request_pkg.sv
// Shared definitions for the multi-core request unit.
//
// Contents:
//   state_t  - access FSM state (IDLE, ACCESS)
//   idx_w()  - width of a core index for a given core count (at least 1 bit)
//
// The per-core request record (ren, wen, addr, data) has parameter-dependent
// field widths. It is therefore declared as a typedef inside the modules that
// use it, next to the ADDR_W/DATA_W parameters that size it.
package request_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  // A single core still needs a 1-bit index so that ports are never zero-width.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin next-grant selector.
//
// Returns the first requesting index strictly after 'last', wrapping modulo
// NCORES. The search order is last+1, last+2, ..., last+NCORES, so the
// previous winner is considered last.
//
// Ports:
//   req   in  NCORES  request vector
//   last  in  IDXW    index of the previous winner
//   grant out IDXW    selected index (0 when valid is low)
//   valid out 1       at least one request present
module rr_arbiter
  import request_pkg::*;
#(
  parameter int NCORES = 2,
  parameter int IDXW   = 1
) (
  input  logic [NCORES-1:0] req,
  input  logic [IDXW-1:0]   last,
  output logic [IDXW-1:0]   grant,
  output logic              valid
);

  int idx;

  always_comb begin
    grant = '0;
    valid = 1'b0;
    idx   = 0;
    for (int k = 1; k <= NCORES; k++) begin
      idx = (int'(last) + k) % NCORES;
      if (!valid && req[idx]) begin
        valid = 1'b1;
        grant = IDXW'(idx);
      end
    end
  end

endmodule

// File: rtl/multi_request_unit.sv
// Multi-core data request unit.
//
// Each core may hold one outstanding data request, captured on its ihit.
// Pending requests are arbitrated round-robin onto a single memory port;
// completion returns a one-cycle dhit and the load data to the requester.
//
// Handshake: a request is captured on an edge where ihit[i]=1, the core has
// nothing pending and dREN[i]|dWEN[i] is set. The core then stalls until its
// dhit[i] pulse. Memory side: mREN/mWEN, maddr and mstore are held stable
// while busy=1 until the edge on which mready=1; mload is sampled on that edge.
//
// Ports:
//   CLK, nRST            clock, asynchronous active-low reset
//   ihit[NCORES]         per-core capture strobe
//   dREN/dWEN[NCORES]    per-core read/write request (write wins if both)
//   daddr, dstore        per-core address/store data, core i at [i*W +: W]
//   flush[NCORES]        cancel a pending, not yet granted request
//   mready, mload        memory completion and read data
//   mREN, mWEN, maddr, mstore  memory request outputs
//   dhit[NCORES]         one-cycle completion pulse (one-hot or zero)
//   dload                load data, held until the next dhit
//   busy                 FSM is in ACCESS (state debug view)
module multi_request_unit
  import request_pkg::*;
#(
  parameter int NCORES = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                     CLK,
  input  logic                     nRST,
  input  logic [NCORES-1:0]        ihit,
  input  logic [NCORES-1:0]        dREN,
  input  logic [NCORES-1:0]        dWEN,
  input  logic [NCORES*ADDR_W-1:0] daddr,
  input  logic [NCORES*DATA_W-1:0] dstore,
  input  logic [NCORES-1:0]        flush,
  input  logic                     mready,
  input  logic [DATA_W-1:0]        mload,
  output logic                     mREN,
  output logic                     mWEN,
  output logic [ADDR_W-1:0]        maddr,
  output logic [DATA_W-1:0]        mstore,
  output logic [NCORES-1:0]        dhit,
  output logic [DATA_W-1:0]        dload,
  output logic                     busy
);

  localparam int IDXW = idx_w(NCORES);

  typedef struct packed {
    logic              ren;
    logic              wen;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } req_t;

  state_t              state, state_n;
  logic [NCORES-1:0]   pend, pend_n;
  req_t                reqs   [NCORES];
  req_t                reqs_n [NCORES];
  logic [IDXW-1:0]     last_grant, last_n;
  logic [IDXW-1:0]     gnt, gnt_n;
  logic                mren_n, mwen_n, busy_n;
  logic [ADDR_W-1:0]   maddr_n;
  logic [DATA_W-1:0]   mstore_n, dload_n;
  logic [NCORES-1:0]   dhit_n;

  // A same-edge flush removes the core from arbitration.
  logic [NCORES-1:0]   eligible;
  logic [IDXW-1:0]     arb_grant;
  logic                arb_valid;

  assign eligible = pend & ~flush;

  rr_arbiter #(
    .NCORES (NCORES),
    .IDXW   (IDXW)
  ) u_arb (
    .req   (eligible),
    .last  (last_grant),
    .grant (arb_grant),
    .valid (arb_valid)
  );

  always_comb begin
    state_n  = state;
    pend_n   = pend;
    reqs_n   = reqs;
    last_n   = last_grant;
    gnt_n    = gnt;
    mren_n   = mREN;
    mwen_n   = mWEN;
    maddr_n  = maddr;
    mstore_n = mstore;
    busy_n   = busy;
    dload_n  = dload;
    dhit_n   = '0;

    // Flush cancels only a request that is not the one currently on the bus.
    for (int i = 0; i < NCORES; i++) begin
      if (flush[i] && pend[i] && !(state == ACCESS && gnt == IDXW'(i)))
        pend_n[i] = 1'b0;
    end

    // Capture uses the registered pend, so a core completing this edge cannot
    // re-capture until the following edge.
    for (int i = 0; i < NCORES; i++) begin
      if (ihit[i] && !pend[i] && !flush[i] && (dREN[i] || dWEN[i])) begin
        pend_n[i]      = 1'b1;
        reqs_n[i].wen  = dWEN[i];
        reqs_n[i].ren  = dREN[i] & ~dWEN[i];
        reqs_n[i].addr = daddr[i*ADDR_W +: ADDR_W];
        reqs_n[i].data = dstore[i*DATA_W +: DATA_W];
      end
    end

    case (state)
      IDLE: begin
        if (arb_valid) begin
          gnt_n    = arb_grant;
          mren_n   = reqs[arb_grant].ren;
          mwen_n   = reqs[arb_grant].wen;
          maddr_n  = reqs[arb_grant].addr;
          mstore_n = reqs[arb_grant].data;
          busy_n   = 1'b1;
          state_n  = ACCESS;
        end
      end
      ACCESS: begin
        if (mready) begin
          mren_n  = 1'b0;
          mwen_n  = 1'b0;
          busy_n  = 1'b0;
          last_n  = gnt;
          dload_n = reqs[gnt].wen ? '0 : mload;
          for (int i = 0; i < NCORES; i++) begin
            if (gnt == IDXW'(i)) begin
              pend_n[i] = 1'b0;
              dhit_n[i] = 1'b1;
            end
          end
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state      <= IDLE;
      pend       <= '0;
      last_grant <= IDXW'(NCORES - 1);
      gnt        <= '0;
      mREN       <= 1'b0;
      mWEN       <= 1'b0;
      maddr      <= '0;
      mstore     <= '0;
      busy       <= 1'b0;
      dload      <= '0;
      dhit       <= '0;
      for (int i = 0; i < NCORES; i++) reqs[i] <= '0;
    end else begin
      state      <= state_n;
      pend       <= pend_n;
      last_grant <= last_n;
      gnt        <= gnt_n;
      mREN       <= mren_n;
      mWEN       <= mwen_n;
      maddr      <= maddr_n;
      mstore     <= mstore_n;
      busy       <= busy_n;
      dload      <= dload_n;
      dhit       <= dhit_n;
      for (int i = 0; i < NCORES; i++) reqs[i] <= reqs_n[i];
    end
  end

endmodule

// File: tb/tb_multi_request_unit.sv
// Self-checking bench for multi_request_unit (NCORES=2).
// Directed scenarios followed by randomized traffic, all checked against a
// request-level reference model and a completion scoreboard.
module tb_multi_request_unit;

  localparam int N  = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW + 8;

  // ---------------- clock / reset ----------------
  logic          CLK = 1'b0;
  logic          nRST;
  logic [N-1:0]  ihit, dREN, dWEN, flush;
  logic [N*AW-1:0] daddr;
  logic [N*DW-1:0] dstore;
  logic          mready;
  logic [DW-1:0] mload;
  logic          mREN, mWEN, busy;
  logic [AW-1:0] maddr;
  logic [DW-1:0] mstore, dload;
  logic [N-1:0]  dhit;

  always #5 CLK = ~CLK;

  multi_request_unit #(.NCORES(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dREN(dREN), .dWEN(dWEN),
    .daddr(daddr), .dstore(dstore), .flush(flush), .mready(mready),
    .mload(mload), .mREN(mREN), .mWEN(mWEN), .maddr(maddr),
    .mstore(mstore), .dhit(dhit), .dload(dload), .busy(busy)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Each core owns at most one request; one request at a time is on the bus.
  bit            m_pend [N];
  bit            m_ren  [N];
  bit            m_wen  [N];
  logic [AW-1:0] m_addr [N];
  logic [DW-1:0] m_data [N];
  bit            m_on_bus;
  int            m_owner;
  int            m_last;
  logic          e_mren, e_mwen, e_busy;
  logic [AW-1:0] e_maddr;
  logic [DW-1:0] e_mstore, e_dload;
  logic [N-1:0]  e_dhit;
  logic [SW-1:0] exp_q[$];

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_pend[i] = 0; m_ren[i] = 0; m_wen[i] = 0; m_addr[i] = '0; m_data[i] = '0;
    end
    m_on_bus = 0; m_owner = 0; m_last = N - 1;
    e_mren = 0; e_mwen = 0; e_busy = 0; e_maddr = '0; e_mstore = '0;
    e_dload = '0; e_dhit = '0;
    exp_q.delete();
  endtask

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_step();
    bit had_pend [N];
    bit found;
    int c;
    for (int i = 0; i < N; i++) had_pend[i] = m_pend[i];
    e_dhit = '0;
    for (int i = 0; i < N; i++)
      if (flush[i] && had_pend[i] && !(m_on_bus && m_owner == i)) m_pend[i] = 0;
    if (!m_on_bus) begin
      found = 0;
      for (int k = 1; k <= N; k++) begin
        c = (m_last + k) % N;
        if (!found && m_pend[c]) begin
          found = 1; m_owner = c; m_on_bus = 1;
          e_mren = m_ren[c]; e_mwen = m_wen[c];
          e_maddr = m_addr[c]; e_mstore = m_data[c]; e_busy = 1;
        end
      end
    end else if (mready) begin
      e_mren = 0; e_mwen = 0; e_busy = 0;
      m_pend[m_owner] = 0; m_last = m_owner; m_on_bus = 0;
      e_dhit[m_owner] = 1'b1;
      e_dload = m_wen[m_owner] ? '0 : mload;
      exp_q.push_back({8'(m_owner), e_dload});
    end
    for (int i = 0; i < N; i++) begin
      if (ihit[i] && !had_pend[i] && !flush[i] && (dREN[i] || dWEN[i])) begin
        m_pend[i] = 1; m_wen[i] = dWEN[i]; m_ren[i] = dREN[i] && !dWEN[i];
        m_addr[i] = daddr[i*AW +: AW]; m_data[i] = dstore[i*DW +: DW];
      end
    end
  endtask

  task automatic check_outputs();
    logic [SW-1:0] got;
    int c;
    check_eq("mREN", mREN, e_mren);
    check_eq("mWEN", mWEN, e_mwen);
    check_eq("busy", busy, e_busy);
    check_eq("maddr", maddr, e_maddr);
    check_eq("mstore", mstore, e_mstore);
    check_eq("dhit", dhit, e_dhit);
    check_eq("dload", dload, e_dload);
    if (dhit != '0) begin
      c = 0;
      for (int i = 0; i < N; i++) if (dhit[i]) c = i;
      check_eq("sb_nonempty", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        got = {8'(c), dload};
        check_eq("sb_completion", got, exp_q.pop_front());
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  // Called at a negedge with inputs already applied.
  task automatic tick();
    model_step();
    @(posedge CLK);
    @(negedge CLK);
    check_outputs();
  endtask

  task automatic idle_inputs();
    ihit = '0; dREN = '0; dWEN = '0; flush = '0; mready = 0; mload = '0;
  endtask

  task automatic set_core(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    daddr[i*AW +: AW] = a;
    dstore[i*DW +: DW] = d;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    idle_inputs();
    nRST = 0;
    model_reset();
    @(posedge CLK);
    @(negedge CLK);
    nRST = 1;
  endtask

  int order[$];

  initial begin
    idle_inputs();
    daddr = '0; dstore = '0;
    nRST = 0;
    model_reset();
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check_eq("rst_mREN", mREN, 0);
    check_eq("rst_mWEN", mWEN, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_dhit", dhit, 0);
    check_eq("rst_dload", dload, 0);
    check_eq("rst_maddr", maddr, 0);
    nRST = 1;

    // Core0 read
    ihit = 2'b01; dREN = 2'b01; set_core(0, 32'h100, 32'h0);
    tick();
    idle_inputs();
    tick();
    check_eq("rd_mREN", mREN, 1);
    check_eq("rd_maddr", maddr, 32'h100);
    check_eq("rd_busy", busy, 1);
    tick(); tick();
    mready = 1; mload = 32'hDEADBEEF;
    tick();
    check_eq("rd_dhit", dhit, 2'b01);
    check_eq("rd_dload", dload, 32'hDEADBEEF);
    check_eq("rd_busy_done", busy, 0);
    idle_inputs();
    tick();
    check_eq("rd_dhit_pulse", dhit, 2'b00);
    check_eq("rd_dload_hold", dload, 32'hDEADBEEF);

    // Simultaneous writes
    do_reset();
    ihit = 2'b11; dWEN = 2'b11;
    set_core(0, 32'h200, 32'h11); set_core(1, 32'h300, 32'h22);
    tick();
    idle_inputs(); mready = 1;
    tick();
    check_eq("wr_first_addr", maddr, 32'h200);
    check_eq("wr_first_mWEN", mWEN, 1);
    check_eq("wr_first_data", mstore, 32'h11);
    tick();
    check_eq("wr_dhit0", dhit, 2'b01);
    tick();
    check_eq("wr_gap_dhit", dhit, 2'b00);
    check_eq("wr_second_addr", maddr, 32'h300);
    tick();
    check_eq("wr_dhit1", dhit, 2'b10);
    check_eq("wr_dload0", dload, 0);
    tick();
    check_eq("wr_dhit_off", dhit, 2'b00);

    // Round-robin with continuous requests
    do_reset();
    ihit = 2'b11; dREN = 2'b11; mready = 1; mload = 32'h5A5A0000;
    set_core(0, 32'hA0, 0); set_core(1, 32'hB0, 0);
    order.delete();
    for (int cyc = 0; cyc < 60 && order.size() < 6; cyc++) begin
      tick();
      if (dhit[0]) order.push_back(0);
      if (dhit[1]) order.push_back(1);
    end
    check_eq("rr_count", order.size(), 6);
    for (int k = 0; k < order.size(); k++) check_eq("rr_order", order[k], k % 2);
    idle_inputs();
    repeat (4) tick();

    // Flush of a waiting core
    do_reset();
    ihit = 2'b01; dREN = 2'b01; set_core(0, 32'h40, 0);
    tick();
    ihit = 2'b10; dREN = 2'b10; set_core(1, 32'h44, 0);
    tick();
    idle_inputs(); flush = 2'b10;
    tick();
    flush = 2'b00; mready = 1; mload = 32'h77;
    tick();
    check_eq("fl_dhit0", dhit, 2'b01);
    idle_inputs();
    for (int k = 0; k < 5; k++) begin
      tick();
      check_eq("fl_no_dhit1", dhit[1], 0);
      check_eq("fl_idle", busy, 0);
    end

    // Reset in the middle of an access
    do_reset();
    ihit = 2'b01; dWEN = 2'b01; set_core(0, 32'h80, 32'h99);
    tick();
    idle_inputs();
    tick(); tick();
    check_eq("ra_busy_before", busy, 1);
    #2 nRST = 0;
    model_reset();
    #1;
    check_eq("ra_mREN", mREN, 0);
    check_eq("ra_mWEN", mWEN, 0);
    check_eq("ra_busy", busy, 0);
    check_eq("ra_dhit", dhit, 0);
    @(posedge CLK);
    @(negedge CLK);
    nRST = 1;
    mready = 1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check_eq("ra_no_access", busy, 0);
    end

    // Read and write both requested
    do_reset();
    ihit = 2'b01; dREN = 2'b01; dWEN = 2'b01; set_core(0, 32'h400, 32'h55);
    tick();
    idle_inputs();
    tick();
    check_eq("rw_mWEN", mWEN, 1);
    check_eq("rw_mREN", mREN, 0);
    mready = 1; mload = 32'hFFFFFFFF;
    tick();
    check_eq("rw_dhit", dhit, 2'b01);
    check_eq("rw_dload", dload, 0);

    // Randomized traffic
    do_reset();
    for (int cyc = 0; cyc < 800; cyc++) begin
      ihit = 2'($urandom_range(0, 3));
      dREN = 2'($urandom_range(0, 3));
      dWEN = 2'($urandom_range(0, 3)) & 2'($urandom_range(0, 3));
      for (int i = 0; i < N; i++) begin
        flush[i] = ($urandom_range(0, 7) == 0);
        set_core(i, $urandom, $urandom);
      end
      mready = ($urandom_range(0, 2) == 0);
      mload = $urandom;
      tick();
    end
    idle_inputs(); mready = 1;
    repeat (8) tick();
    check_eq("sb_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
